// File: rtl/ebpc_stream_merger.sv
// Merges a frame's ZNZ burst then its BPC burst into one stream; EBPC_MERGER_TRAILER_EN appends ZNZ/BPC word counts.
// Latency: 1 cycle from input accept to vld_o, one word per cycle sustained.
// Backpressure: single output register; upstream rdy only in the active phase while the register is empty or draining.
package ebpc_pkg;
    parameter int unsigned DATA_W = 8;
endpackage

module ebpc_stream_merger #(
    parameter int unsigned DATA_W = ebpc_pkg::DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] znz_data_i,
    input  logic              znz_last_i,
    input  logic              znz_vld_i,
    output logic              znz_rdy_o,
    input  logic [DATA_W-1:0] bpc_data_i,
    input  logic              bpc_last_i,
    input  logic              bpc_vld_i,
    output logic              bpc_rdy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              idle_o,
    output logic              frame_done_o
);

    typedef enum logic [2:0] {IDLE, ZNZ, BPC, TRAILER0, TRAILER1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  znz_cnt_q, bpc_cnt_q;
    logic [CNT_W-1:0]  znz_base, bpc_base;
    logic              can_load, znz_acc, bpc_acc;
    logic              load, load_last;
    logic [DATA_W-1:0] load_dat;

    assign can_load     = ~vld_o | rdy_i;
    assign znz_rdy_o    = ~rst_i & can_load & ((state_q == IDLE) | (state_q == ZNZ));
    assign bpc_rdy_o    = ~rst_i & can_load & (state_q == BPC);
    assign znz_acc      = znz_vld_i & znz_rdy_o;
    assign bpc_acc      = bpc_vld_i & bpc_rdy_o;
    assign frame_done_o = vld_o & last_o & rdy_i;
    assign idle_o       = (state_q == IDLE) & ~vld_o;

    // A new frame may start counting in the same cycle the previous one retires.
    assign znz_base = frame_done_o ? '0 : znz_cnt_q;
    assign bpc_base = frame_done_o ? '0 : bpc_cnt_q;

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_dat  = '0;
        load_last = 1'b0;
        case (state_q)
            IDLE, ZNZ: begin
                load     = znz_acc;
                load_dat = znz_data_i;
                if (znz_acc && znz_last_i) begin
                    state_d = BPC;
                end else if (znz_vld_i) begin
                    state_d = ZNZ;
                end
            end
            BPC: begin
                load     = bpc_acc;
                load_dat = bpc_data_i;
                if (bpc_acc && bpc_last_i) begin
`ifdef EBPC_MERGER_TRAILER_EN
                    state_d   = TRAILER0;
`else
                    load_last = 1'b1;
                    state_d   = IDLE;
`endif
                end
            end
`ifdef EBPC_MERGER_TRAILER_EN
            TRAILER0: begin
                if (can_load) begin
                    load     = 1'b1;
                    load_dat = znz_cnt_q[DATA_W-1:0];
                    state_d  = TRAILER1;
                end
            end
            TRAILER1: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_dat  = bpc_cnt_q[DATA_W-1:0];
                    load_last = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            vld_o     <= 1'b0;
            last_o    <= 1'b0;
            data_o    <= '0;
            znz_cnt_q <= '0;
            bpc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            znz_cnt_q <= (znz_acc && (znz_base != '1)) ? znz_base + CNT_W'(1) : znz_base;
            bpc_cnt_q <= (bpc_acc && (bpc_base != '1)) ? bpc_base + CNT_W'(1) : bpc_base;
            if (load) begin
                vld_o  <= 1'b1;
                data_o <= load_dat;
                last_o <= load_last;
            end else if (rdy_i) begin
                vld_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ebpc_stream_merger.sv
// Randomised and directed bench for ebpc_stream_merger against a frame-level queue model.
`timescale 1ns/1ps
module tb_ebpc_stream_merger;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int CLK_P = 10;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] znz_data_i, bpc_data_i, data_o;
    logic          znz_last_i, znz_vld_i, znz_rdy_o;
    logic          bpc_last_i, bpc_vld_i, bpc_rdy_o;
    logic          last_o, vld_o, rdy_i, idle_o, frame_done_o;

    ebpc_stream_merger #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .znz_data_i(znz_data_i), .znz_last_i(znz_last_i), .znz_vld_i(znz_vld_i), .znz_rdy_o(znz_rdy_o),
        .bpc_data_i(bpc_data_i), .bpc_last_i(bpc_last_i), .bpc_vld_i(bpc_vld_i), .bpc_rdy_o(bpc_rdy_o),
        .data_o(data_o), .last_o(last_o), .vld_o(vld_o), .rdy_i(rdy_i),
        .idle_o(idle_o), .frame_done_o(frame_done_o)
    );

    always #(CLK_P/2) clk_i = ~clk_i;

    word_t         znz_q[$], bpc_q[$];
    logic [DW:0]   exp_q[$], obs_q[$], lit[$];
    logic [DW-1:0] zstage[$], bstage[$];
    int            checks = 0, failures = 0;
    int            znz_fr = 0, bpc_fr = 0, zacc_cnt = 0, fd_cnt = 0;
    int            gap_pct = 0, rdy_mode = 0;
    bit            znz_hold = 1'b0, zfire, bfire, stall_prev = 1'b0;
    longint        zfirst_t = -1, xfirst_t = 0, xlast_t = 0;
    logic [DW:0]   held, mon_e;
    word_t         wz, wb;

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

`ifdef EBPC_MERGER_TRAILER_EN
    function automatic logic [DW-1:0] trailer_val(input int n);
        int m;
        m = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
        return m[DW-1:0];
    endfunction
`endif

    // Frame-level model: output is every ZNZ word, every BPC word, then the optional count trailer.
    task automatic add_frame();
        int nz, nb;
        nz = zstage.size();
        nb = bstage.size();
        for (int i = 0; i < nz; i++) begin
            znz_q.push_back('{d: zstage[i], l: (i == nz - 1)});
            exp_q.push_back({1'b0, zstage[i]});
        end
        for (int i = 0; i < nb; i++) begin
            bpc_q.push_back('{d: bstage[i], l: (i == nb - 1)});
`ifdef EBPC_MERGER_TRAILER_EN
            exp_q.push_back({1'b0, bstage[i]});
`else
            exp_q.push_back({(i == nb - 1), bstage[i]});
`endif
        end
`ifdef EBPC_MERGER_TRAILER_EN
        exp_q.push_back({1'b0, trailer_val(nz)});
        exp_q.push_back({1'b1, trailer_val(nb)});
`endif
        zstage.delete();
        bstage.delete();
    endtask

    task automatic stage_base();
        zstage = '{8'h11, 8'h22, 8'h33};
        bstage = '{8'hA1, 8'hA2};
    endtask

    task automatic set_base_lit();
`ifdef EBPC_MERGER_TRAILER_EN
        lit = '{9'h011, 9'h022, 9'h033, 9'h0A1, 9'h0A2, 9'h003, 9'h102};
`else
        lit = '{9'h011, 9'h022, 9'h033, 9'h0A1, 9'h1A2};
`endif
    endtask

    task automatic check_lit(input string nm);
        check({nm, "_count"}, obs_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < obs_q.size(); i++) check(nm, obs_q[i], lit[i]);
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < limit)) begin
            @(negedge clk_i);
            n++;
        end
        check({nm, "_drained"}, exp_q.size(), 0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic reset_and_check(input string nm);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        znz_q.delete(); bpc_q.delete(); exp_q.delete();
        znz_vld_i = 1'b0; bpc_vld_i = 1'b0;
        znz_fr = 0; bpc_fr = 0;
        @(negedge clk_i);
        check({nm, "_znz_rdy_in_rst"}, znz_rdy_o, 0);
        check({nm, "_bpc_rdy_in_rst"}, bpc_rdy_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check({nm, "_vld"}, vld_o, 0);
        check({nm, "_last"}, last_o, 0);
        check({nm, "_data"}, data_o, 0);
        check({nm, "_frame_done"}, frame_done_o, 0);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        check({nm, "_idle_after"}, idle_o, 1);
    endtask

    // Output scoreboard and stall-stability monitor.
    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (frame_done_o) fd_cnt++;
            if (stall_prev) begin
                check("stall_vld_held", vld_o, 1);
                check("stall_word_held", {last_o, data_o}, held);
            end
            if (vld_o && rdy_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: actual=0x%0h required=none", {last_o, data_o});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_word", {last_o, data_o}, mon_e);
                    check("frame_done_on_xfer", frame_done_o, mon_e[DW]);
                end
                if (obs_q.size() == 0) xfirst_t = $time;
                xlast_t = $time;
                obs_q.push_back({last_o, data_o});
            end else begin
                check("frame_done_quiet", frame_done_o, 0);
            end
            stall_prev = vld_o && !rdy_i;
            held = {last_o, data_o};
        end
    end

    initial begin : znz_drv
        znz_vld_i = 1'b0; znz_data_i = '0; znz_last_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (znz_vld_i && !rst_i && (znz_fr != bpc_fr)) check("znz_rdy_gated", znz_rdy_o, 0);
            zfire = znz_vld_i && znz_rdy_o && !rst_i;
            if (zfire && zfirst_t < 0) zfirst_t = $time;
            @(posedge clk_i); #1;
            if (zfire && znz_q.size() > 0) begin
                wz = znz_q.pop_front();
                znz_vld_i = 1'b0;
                zacc_cnt++;
                if (wz.l) znz_fr++;
            end
            if (!rst_i && !znz_hold && !znz_vld_i && znz_q.size() > 0 && ($urandom_range(0, 99) >= gap_pct)) begin
                znz_data_i = znz_q[0].d;
                znz_last_i = znz_q[0].l;
                znz_vld_i  = 1'b1;
            end
        end
    end

    initial begin : bpc_drv
        bpc_vld_i = 1'b0; bpc_data_i = '0; bpc_last_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bpc_vld_i && !rst_i && (znz_fr == bpc_fr)) check("bpc_rdy_gated", bpc_rdy_o, 0);
            bfire = bpc_vld_i && bpc_rdy_o && !rst_i;
            @(posedge clk_i); #1;
            if (bfire && bpc_q.size() > 0) begin
                wb = bpc_q.pop_front();
                bpc_vld_i = 1'b0;
                if (wb.l) bpc_fr++;
            end
            if (!rst_i && !bpc_vld_i && bpc_q.size() > 0 && ($urandom_range(0, 99) >= gap_pct)) begin
                bpc_data_i = bpc_q[0].d;
                bpc_last_i = bpc_q[0].l;
                bpc_vld_i  = 1'b1;
            end
        end
    end

    initial begin : rdy_drv
        rdy_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       rdy_i = 1'b1;
                1:       rdy_i = ~rdy_i;
                default: rdy_i = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        reset_and_check("por");
        check("por_znz_rdy_idle", znz_rdy_o, 1);

        // Basic frame, full-rate sink.
        obs_q.delete(); fd_cnt = 0; zfirst_t = -1;
        stage_base(); add_frame();
        wait_drain("p1", 200);
        set_base_lit(); check_lit("p1_order");
        check("p1_latency", xfirst_t - zfirst_t, CLK_P);
        check("p1_frame_done", fd_cnt, 1);

        // Alternating sink ready.
        rdy_mode = 1; obs_q.delete(); fd_cnt = 0;
        stage_base(); add_frame();
        wait_drain("p2", 200);
        check_lit("p2_order");
        check("p2_frame_done", fd_cnt, 1);
        rdy_mode = 0;

        // BPC offered well before ZNZ finishes.
        obs_q.delete(); fd_cnt = 0; znz_hold = 1'b1;
        stage_base(); add_frame();
        repeat (2) @(posedge clk_i);
        check("p3_bpc_blocked", obs_q.size(), 0);
        znz_hold = 1'b0;
        wait_drain("p3", 200);
        check_lit("p3_order");

        // Two frames back to back.
        obs_q.delete(); fd_cnt = 0;
        stage_base(); add_frame();
        zstage = '{8'h44, 8'h55}; bstage = '{8'hB1}; add_frame();
        wait_drain("p4", 200);
        set_base_lit();
`ifdef EBPC_MERGER_TRAILER_EN
        lit.push_back(9'h044); lit.push_back(9'h055); lit.push_back(9'h0B1);
        lit.push_back(9'h002); lit.push_back(9'h101);
`else
        lit.push_back(9'h044); lit.push_back(9'h055); lit.push_back(9'h1B1);
`endif
        check_lit("p4_order");
        check("p4_frame_done", fd_cnt, 2);
        check("p4_no_bubble", (xlast_t - xfirst_t) / CLK_P + 1, obs_q.size());

        // Reset in the middle of a frame.
        zacc_cnt = 0;
        zstage = '{8'h61, 8'h62, 8'h63, 8'h64}; bstage = '{8'hC1}; add_frame();
        for (int n = 0; n < 100 && zacc_cnt < 2; n++) begin
            @(posedge clk_i); #2;
        end
        check("p5_two_accepted", zacc_cnt, 2);
        reset_and_check("p5_rst");
        obs_q.delete(); fd_cnt = 0;
        stage_base(); add_frame();
        wait_drain("p5", 200);
        set_base_lit(); check_lit("p5_after_rst");
        check("p5_frame_done", fd_cnt, 1);

        // Random traffic, gaps and backpressure, including a counter-saturating frame.
        rdy_mode = 2; gap_pct = 30; fd_cnt = 0;
        for (int f = 0; f < 12; f++) begin
            int nz, nb;
            nz = (f == 5) ? 300 : $urandom_range(1, 6);
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nz; i++) zstage.push_back(DW'($urandom));
            for (int i = 0; i < nb; i++) bstage.push_back(DW'($urandom));
            add_frame();
        end
        wait_drain("p6", 20000);
        check("p6_frame_done", fd_cnt, 12);
        check("p6_idle_end", idle_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
